imem_loader: RTL and testbench

//  Fills instruction memory from a byte stream before the single-cycle core runs.

---
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream before the core runs.
// Bytes are packed big-endian into 32-bit words and written through the memory write
// port. A trailing checksum byte (XOR of all data bytes) is compared at the end; only a
// clean load releases the core from reset.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high
//   start      - 1-cycle load request, accepted in IDLE/DONE/ERROR
//   num_words  - words to load (clamped to 2**ADDR_WIDTH), latched on start
//   in_valid   - stream byte available on in_data
//   in_data    - stream byte
//   in_ready   - loader accepts a byte this cycle
//   mem_we     - instruction memory write strobe, one cycle per word
//   mem_addr   - byte address of the write (BASE_ADDR + 4*wordIdx)
//   mem_wdata  - assembled word
//   core_reset - core reset, low only in DONE
//   busy       - load in progress (RECV/WRITE/CHECK)
//   done       - clean load finished
//   error      - checksum mismatch
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone,
    StError
  } stateT;

  localparam logic [ADDR_WIDTH:0] MaxWords = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OneWord  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  stateT                 state;
  logic [ADDR_WIDTH:0]   numWords;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            byteCnt;
  logic [7:0]            xorAcc;
  logic [31:0]           wdata;

  logic                  xfer;
  logic                  lastWord;
  logic [ADDR_WIDTH:0]   numWordsClamped;
  logic [ADDR_WIDTH:0]   lastIdx;

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign in_ready   = (state == StRecv) || (state == StCheck);
  assign mem_we     = (state == StWrite);
  assign busy       = (state == StRecv) || (state == StWrite) || (state == StCheck);
  assign done       = (state == StDone);
  assign error      = (state == StError);
  assign core_reset = (state != StDone);
  assign mem_wdata  = wdata;
  assign mem_addr   = BASE_ADDR + {{(30 - ADDR_WIDTH){1'b0}}, wordIdx, 2'b00};

  assign xfer            = in_valid && in_ready;
  assign numWordsClamped = (num_words > MaxWords) ? MaxWords : num_words;
  assign lastIdx         = numWords - OneWord;
  assign lastWord        = ({1'b0, wordIdx} == lastIdx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      numWords <= '0;
      wordIdx  <= '0;
      byteCnt  <= '0;
      xorAcc   <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        StIdle, StDone, StError: begin
          if (start) begin
            numWords <= numWordsClamped;
            wordIdx  <= '0;
            byteCnt  <= '0;
            xorAcc   <= '0;
            state    <= (num_words == '0) ? StCheck : StRecv;
          end
        end
        StRecv: begin
          if (xfer) begin
            wdata   <= {wdata[23:0], in_data};
            xorAcc  <= xorAcc ^ in_data;
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) state <= StWrite;
          end
        end
        StWrite: begin
          // Index holds on the last word so the address never wraps past the top.
          if (lastWord) begin
            state <= StCheck;
          end else begin
            wordIdx <= wordIdx + 1'b1;
            state   <= StRecv;
          end
        end
        StCheck: begin
          if (xfer) state <= (in_data == xorAcc) ? StDone : StError;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one instance with ADDR_WIDTH=8 and one with
// ADDR_WIDTH=2 for the top-of-memory case. A negedge monitor captures every write
// of the selected instance and checks that each strobe follows a 4th data byte.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startA = 1'b0;
  logic        startB = 1'b0;
  logic [8:0]  nwA = '0;
  logic [2:0]  nwB = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        rdyA, weA, crA, busyA, doneA, errA;
  logic [31:0] addrA, dataA;
  logic        rdyB, weB, crB, busyB, doneB, errB;
  logic [31:0] addrB, dataB;

  int          nTests = 0;
  int          nFail = 0;
  bit          sel = 1'b0;

  logic [31:0] wAddr[$];
  logic [31:0] wData[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dutA (
    .clk(clk), .reset(reset), .start(startA), .num_words(nwA),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdyA),
    .mem_we(weA), .mem_addr(addrA), .mem_wdata(dataA),
    .core_reset(crA), .busy(busyA), .done(doneA), .error(errA)
  );

  imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(32'h0000_0000)) dutB (
    .clk(clk), .reset(reset), .start(startB), .num_words(nwB),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdyB),
    .mem_we(weB), .mem_addr(addrB), .mem_wdata(dataB),
    .core_reset(crB), .busy(busyB), .done(doneB), .error(errB)
  );

  logic        rdyM, weM, busyM, doneM, errM, crM, startM;
  logic [31:0] addrM, dataM;
  assign rdyM   = sel ? rdyB  : rdyA;
  assign weM    = sel ? weB   : weA;
  assign busyM  = sel ? busyB : busyA;
  assign doneM  = sel ? doneB : doneA;
  assign errM   = sel ? errB  : errA;
  assign crM    = sel ? crB   : crA;
  assign startM = sel ? startB : startA;
  assign addrM  = sel ? addrB : addrA;
  assign dataM  = sel ? dataB : dataA;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int xferCnt = 0;
  bit fourthPrev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      xferCnt    = 0;
      fourthPrev = 1'b0;
    end else begin
      if (weM) begin
        check("we_after_4th_byte", 32'(fourthPrev), 32'd1);
        wAddr.push_back(addrM);
        wData.push_back(dataM);
      end
      if (startM && !busyM) begin
        xferCnt    = 0;
        fourthPrev = 1'b0;
      end else if (in_valid && rdyM) begin
        fourthPrev = ((xferCnt % 4) == 3);
        xferCnt++;
      end else begin
        fourthPrev = 1'b0;
      end
    end
  end

  // All main-thread activity happens 1 time unit after a rising edge.
  task automatic pulseStart(input int nw);
    nwA = 9'(nw);
    nwB = 3'(nw);
    if (sel) startB = 1'b1;
    else     startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rnd);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_data = b;
    while (!acc && n < 200) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && rdyM;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendStream(input logic [7:0] s[$], input bit rnd);
    foreach (s[i]) sendByte(s[i], rnd);
  endtask

  task automatic waitEnd(input string tag);
    int n;
    n = 0;
    while (!(doneM || errM) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_finished"}, 32'(doneM || errM), 32'd1);
  endtask

  task automatic checkWrites(input string tag, input int base,
                             input logic [31:0] ea[$], input logic [31:0] ed[$]);
    check({tag, "_nwrites"}, 32'(wAddr.size() - base), 32'(ea.size()));
    for (int i = 0; i < ea.size() && (base + i) < wAddr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wAddr[base + i], ea[i]);
      check($sformatf("%s_data%0d", tag, i), wData[base + i], ed[i]);
    end
  endtask

  // Checksum is the XOR of all eight data bytes, which is 0x00 for this stream.
  logic [7:0]  s2Good[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
  logic [7:0]  s2Bad[$]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h09};
  logic [31:0] e2Addr[$] = '{32'h0, 32'h4};
  logic [31:0] e2Data[$] = '{32'h1234_5678, 32'h9ABC_DEF0};
  logic [31:0] eNone[$]  = '{};
  logic [7:0]  s0[$]     = '{8'h00};
  // Bytes 0x01..0x10; XOR of 0x01..0x0F is 0, so the checksum is 0x10.
  logic [7:0]  s6[$]     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10};
  logic [31:0] e6Addr[$] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] e6Data[$] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};

  initial begin
    int base;

    // T1: reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(rdyA), 32'd0);
    check("rst_mem_we", 32'(weA), 32'd0);
    check("rst_mem_addr", addrA, 32'h0);
    check("rst_mem_wdata", dataA, 32'h0);
    check("rst_core_reset", 32'(crA), 32'd1);
    check("rst_busy", 32'(busyA), 32'd0);
    check("rst_done", 32'(doneA), 32'd0);
    check("rst_error", 32'(errA), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: reset mid-RECV after two bytes
    base = wAddr.size();
    pulseStart(2);
    sendByte(8'h12, 1'b0);
    sendByte(8'h34, 1'b0);
    check("midrst_busy_before", 32'(busyA), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busyA), 32'd0);
    check("midrst_in_ready", 32'(rdyA), 32'd0);
    check("midrst_wdata", dataA, 32'h0);
    check("midrst_core_reset", 32'(crA), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_nwrites", 32'(wAddr.size() - base), 32'd0);

    // T2 + T5b: clean two-word load with a start pulse and num_words change mid-load
    base = wAddr.size();
    pulseStart(2);
    check("t2_busy", 32'(busyA), 32'd1);
    check("t2_core_reset_busy", 32'(crA), 32'd1);
    for (int i = 0; i < 3; i++) sendByte(s2Good[i], 1'b0);
    pulseStart(5);
    for (int i = 3; i < s2Good.size(); i++) sendByte(s2Good[i], 1'b0);
    waitEnd("t2");
    check("t2_done", 32'(doneA), 32'd1);
    check("t2_error", 32'(errA), 32'd0);
    check("t2_core_reset", 32'(crA), 32'd0);
    check("t2_busy_end", 32'(busyA), 32'd0);
    checkWrites("t2", base, e2Addr, e2Data);

    // T3: bad checksum, then reload with the good stream
    base = wAddr.size();
    pulseStart(2);
    check("t3_core_reset_rises", 32'(crA), 32'd1);
    sendStream(s2Bad, 1'b0);
    waitEnd("t3bad");
    check("t3_error", 32'(errA), 32'd1);
    check("t3_done", 32'(doneA), 32'd0);
    check("t3_core_reset", 32'(crA), 32'd1);
    checkWrites("t3bad", base, e2Addr, e2Data);
    base = wAddr.size();
    pulseStart(2);
    sendStream(s2Good, 1'b0);
    waitEnd("t3good");
    check("t3_redo_done", 32'(doneA), 32'd1);
    check("t3_redo_error", 32'(errA), 32'd0);
    checkWrites("t3good", base, e2Addr, e2Data);

    // T4: random in_valid gaps
    base = wAddr.size();
    pulseStart(2);
    sendStream(s2Good, 1'b1);
    waitEnd("t4");
    check("t4_done", 32'(doneA), 32'd1);
    checkWrites("t4", base, e2Addr, e2Data);

    // T5: zero-word load goes straight to the checksum
    base = wAddr.size();
    pulseStart(0);
    check("t5_in_ready", 32'(rdyA), 32'd1);
    sendStream(s0, 1'b0);
    waitEnd("t5");
    check("t5_done", 32'(doneA), 32'd1);
    checkWrites("t5", base, eNone, eNone);

    // T6: ADDR_WIDTH=2, full memory, then an oversize request clamped to 4
    sel = 1'b1;
    @(posedge clk); #1;
    base = wAddr.size();
    pulseStart(4);
    sendStream(s6, 1'b0);
    waitEnd("t6");
    check("t6_done", 32'(doneB), 32'd1);
    check("t6_core_reset", 32'(crB), 32'd0);
    checkWrites("t6", base, e6Addr, e6Data);
    base = wAddr.size();
    pulseStart(7);
    sendStream(s6, 1'b0);
    waitEnd("t6clamp");
    check("t6clamp_done", 32'(doneB), 32'd1);
    checkWrites("t6clamp", base, e6Addr, e6Data);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", nTests, nFail);
    $fatal(1, "watchdog");
  end

endmodule
